// File: rtl/colparity_pkg.sv
// Shared types and default sizes for the column-parity sequencer.
package colparity_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Default row width and memory address width
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 6;

endpackage : colparity_pkg

// File: rtl/colparity_if.sv
// Control and memory-port bundle for the column-parity sequencer.
// The slave modport is the sequencer; the master modport is its environment
// (top-level control plus the matrix memory).
interface colparity_if
   import colparity_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   row_count;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] parity_out;

   modport slave (
      input  start, base_addr, row_count, mem_data,
      output mem_rd, mem_addr, busy, done, parity_out
   );

   modport master (
      output start, base_addr, row_count, mem_data,
      input  mem_rd, mem_addr, busy, done, parity_out
   );

endinterface : colparity_if

// File: rtl/colparity_row_addr_gen.sv
// Row address up-counter and remaining-row down-counter for the sequencer.
// o_addr_nxt exposes the value the address counter will take at the next
// edge, so the owner can register a memory address that lines up with it.
module row_addr_gen #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W:0]   i_count,
   output logic [ADDR_W-1:0] o_addr,
   output logic [ADDR_W-1:0] o_addr_nxt,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_rem;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [ADDR_W:0]   w_rem_nxt;

   // Next values: load wins over step; address wraps naturally modulo 2^ADDR_W
   always_comb begin
      w_addr_nxt = r_addr;
      w_rem_nxt  = r_rem;
      if (i_load) begin
         w_addr_nxt = i_base;
         w_rem_nxt  = i_count;
      end else if (i_step) begin
         w_addr_nxt = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
         w_rem_nxt  = r_rem - {{ADDR_W{1'b0}}, 1'b1};
      end else begin
         w_addr_nxt = r_addr;
         w_rem_nxt  = r_rem;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= {ADDR_W{1'b0}};
         r_rem  <= {(ADDR_W+1){1'b0}};
      end else begin
         r_addr <= w_addr_nxt;
         r_rem  <= w_rem_nxt;
      end
   end

   assign o_addr     = r_addr;
   assign o_addr_nxt = w_addr_nxt;
   assign o_last     = (r_rem == {{ADDR_W{1'b0}}, 1'b1});

endmodule : row_addr_gen

// File: rtl/colparity_ctrl.sv
// Column-parity sequencer: walks a block of matrix rows, one read per cycle,
// XOR-accumulates the returned rows and presents the result with a done pulse.
// All interface outputs are registered from the next-state decode so they
// change only on the clock edge.
module colparity_ctrl
   import colparity_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   colparity_if.slave  bus
);

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_mem_rd;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_parity_out;
   logic              r_rd_d1;
   logic [DATA_W-1:0] r_acc;

   logic              w_accept;
   logic              w_last;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_mem_rd_nxt;
   logic [ADDR_W-1:0] w_mem_addr_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic [DATA_W-1:0] w_acc_nxt;
   logic [DATA_W-1:0] w_parity_nxt;

   // A start is only honoured in IDLE; everywhere else it is ignored
   assign w_accept = (r_state == ST_IDLE) && bus.start;

   row_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_row_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept),
      .i_step     (r_state == ST_READ),
      .i_base     (bus.base_addr),
      .i_count    (bus.row_count),
      .o_addr     (w_addr),
      .o_addr_nxt (w_addr_nxt),
      .o_last     (w_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.row_count != {(ADDR_W+1){1'b0}}) begin
                  w_state_nxt = ST_READ;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            if (w_last) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         ST_DRAIN: w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output and datapath next values, decoded from the upcoming state.
   // mem_addr only moves when a read will be issued, so it holds otherwise.
   // parity_out is cleared on accept and loaded with the final accumulation
   // on entry to DONE, so it reads 0 for the rest of the operation.
   always_comb begin
      w_mem_rd_nxt   = (w_state_nxt == ST_READ);
      w_busy_nxt     = (w_state_nxt != ST_IDLE);
      w_done_nxt     = (w_state_nxt == ST_DONE);
      w_mem_addr_nxt = r_mem_addr;
      w_acc_nxt      = r_acc;
      w_parity_nxt   = r_parity_out;
      if (w_state_nxt == ST_READ) begin
         w_mem_addr_nxt = w_addr_nxt;
      end else begin
         w_mem_addr_nxt = r_mem_addr;
      end
      if (w_accept) begin
         w_acc_nxt = {DATA_W{1'b0}};
      end else if (r_rd_d1) begin
         w_acc_nxt = r_acc ^ bus.mem_data;
      end else begin
         w_acc_nxt = r_acc;
      end
      if (w_accept) begin
         w_parity_nxt = {DATA_W{1'b0}};
      end else if (w_state_nxt == ST_DONE) begin
         w_parity_nxt = w_acc_nxt;
      end else begin
         w_parity_nxt = r_parity_out;
      end
   end

   // Registered outputs, read-valid delay line and accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_rd     <= 1'b0;
         r_mem_addr   <= {ADDR_W{1'b0}};
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_parity_out <= {DATA_W{1'b0}};
         r_rd_d1      <= 1'b0;
         r_acc        <= {DATA_W{1'b0}};
      end else begin
         r_mem_rd     <= w_mem_rd_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_parity_out <= w_parity_nxt;
         r_rd_d1      <= r_mem_rd;
         r_acc        <= w_acc_nxt;
      end
   end

   assign bus.mem_rd     = r_mem_rd;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.parity_out = r_parity_out;

   // The live address counter is consumed through its next value only
   logic w_addr_unused;
   assign w_addr_unused = ^w_addr;

endmodule : colparity_ctrl

// File: tb/tb_colparity_ctrl.sv
// Directed self-checking bench for colparity_ctrl with a behavioural
// one-cycle-latency matrix memory.
module tb_colparity_ctrl;

   logic clk;
   logic rst;
   int   vec_cnt;
   int   err_cnt;
   logic [15:0] mem [0:63];

   colparity_if #(.DATA_W(16), .ADDR_W(6)) bus ();

   colparity_ctrl #(.DATA_W(16), .ADDR_W(6)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: data valid one cycle after mem_rd, junk otherwise
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
      else            bus.mem_data <= 16'hBEEF;
   end

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue a job at the current negedge and follow it to done.
   // inj_k: cycle after accept in which a junk start is driven (0 = none).
   // inj_done: also drive a junk start in the done cycle (left high on return).
   task automatic run_job(input string tag, input logic [5:0] base, input logic [6:0] cnt,
                          input logic [15:0] exp_par, input int exp_lat,
                          input int inj_k, input bit inj_done);
      logic [5:0] q_addr[$];
      logic [5:0] ea;
      int  k;
      bit  seen;
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.row_count = cnt;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      seen = 1'b0;
      k = 1;
      while (!seen && k <= int'(cnt) + 10) begin
         if (bus.mem_rd) q_addr.push_back(bus.mem_addr);
         check_vec({tag, "_busy"}, 32'(bus.busy), 32'd1);
         if (bus.done) begin
            seen = 1'b1;
            check_vec({tag, "_latency"}, 32'(k), 32'(exp_lat));
            check_vec({tag, "_parity"}, 32'(bus.parity_out), 32'(exp_par));
         end else begin
            check_vec({tag, "_parity_cleared"}, 32'(bus.parity_out), 32'd0);
         end
         if (k == inj_k || (seen && inj_done)) begin
            bus.start     = 1'b1;
            bus.base_addr = 6'd40;
            bus.row_count = 7'd5;
         end else begin
            bus.start = 1'b0;
         end
         if (!seen) begin
            @(negedge clk);
            k++;
         end
      end
      check_vec({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_vec({tag, "_num_reads"}, 32'(q_addr.size()), 32'(cnt));
      for (int i = 0; i < q_addr.size(); i++) begin
         ea = base + 6'(i);
         check_vec({tag, "_addr"}, 32'(q_addr[i]), 32'(ea));
      end
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = 6'd0;
      bus.row_count = 7'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check_vec("rst_busy",   32'(bus.busy),       32'd0);
      check_vec("rst_done",   32'(bus.done),       32'd0);
      check_vec("rst_mem_rd", 32'(bus.mem_rd),     32'd0);
      check_vec("rst_addr",   32'(bus.mem_addr),   32'd0);
      check_vec("rst_parity", 32'(bus.parity_out), 32'd0);

      // 1: single row
      mem[5] = 16'hA5A5;
      @(negedge clk);
      run_job("t1", 6'd5, 7'd1, 16'hA5A5, 3, 0, 1'b0);
      @(negedge clk);
      check_vec("t1_done_pulse", 32'(bus.done),       32'd0);
      check_vec("t1_idle_busy",  32'(bus.busy),       32'd0);
      check_vec("t1_idle_rd",    32'(bus.mem_rd),     32'd0);
      check_vec("t1_addr_hold",  32'(bus.mem_addr),   32'd5);
      check_vec("t1_par_hold",   32'(bus.parity_out), 32'h0000A5A5);

      // 2: four rows
      mem[0] = 16'h0001; mem[1] = 16'h0003; mem[2] = 16'h00F0; mem[3] = 16'hFFFF;
      @(negedge clk);
      run_job("t2", 6'd0, 7'd4, 16'hFF0D, 6, 0, 1'b0);
      @(negedge clk);
      check_vec("t2_par_hold", 32'(bus.parity_out), 32'h0000FF0D);

      // 4: zero count after a nonzero result
      @(negedge clk);
      run_job("t4", 6'd9, 7'd0, 16'h0000, 1, 0, 1'b0);
      @(negedge clk);
      check_vec("t4_addr_hold", 32'(bus.mem_addr), 32'd3);

      // 3a: address wrap 62, 63, 0
      mem[62] = 16'h1234; mem[63] = 16'h8000;
      @(negedge clk);
      run_job("t3a", 6'd62, 7'd3, 16'h9235, 5, 0, 1'b0);

      // 3b: full sweep of 64 rows of 0x0001
      for (int i = 0; i < 64; i++) mem[i] = 16'h0001;
      @(negedge clk);
      run_job("t3b", 6'd0, 7'd64, 16'h0000, 66, 0, 1'b0);

      // 5: starts during READ and DONE ignored; start right after done accepted
      mem[8] = 16'h0F00; mem[9] = 16'h00F0; mem[10] = 16'h000F;
      @(negedge clk);
      run_job("t5a", 6'd8, 7'd3, 16'h0FFF, 5, 2, 1'b1);
      @(negedge clk);
      run_job("t5b", 6'd5, 7'd1, 16'h0001, 3, 0, 1'b0);

      // 6: reset mid-operation
      mem[16] = 16'h0101; mem[17] = 16'h1010;
      for (int i = 18; i < 24; i++) mem[i] = 16'hFFFF;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.base_addr = 6'd16;
      bus.row_count = 7'd8;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check_vec("t6_pre_rd", 32'(bus.mem_rd), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_vec("t6_busy",   32'(bus.busy),       32'd0);
      check_vec("t6_done",   32'(bus.done),       32'd0);
      check_vec("t6_mem_rd", 32'(bus.mem_rd),     32'd0);
      check_vec("t6_addr",   32'(bus.mem_addr),   32'd0);
      check_vec("t6_parity", 32'(bus.parity_out), 32'd0);
      @(negedge clk);
      check_vec("t6_idle_busy",   32'(bus.busy),       32'd0);
      check_vec("t6_idle_parity", 32'(bus.parity_out), 32'd0);
      run_job("t6b", 6'd16, 7'd2, 16'h1111, 4, 0, 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_colparity_ctrl
